// File: rtl/display_scan_controller.sv
// Time-multiplexed scan scheduler for a 4-digit seven-segment display.
// Frame-latched snapshot, inter-digit blanking and per-digit blink; all outputs registered.
module display_scan_controller #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYC    = 1000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        disp_en_i,
    input  logic [15:0] digits_i,
    input  logic [3:0]  blink_mask_i,
    input  logic        dp_in_i,
    output logic [3:0]  x_o,
    output logic [1:0]  sw_o,
    output logic        dec_o,
    output logic        seg_en_o,
    output logic        frame_start_o
);

    localparam int unsigned MaxCyc = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
    localparam int unsigned FrmW   = $clog2(BLINK_FRAMES) + 1;

    localparam logic [CntW-1:0] ShowLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [FrmW-1:0] FrameLast = FrmW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {StOff, StShow, StBlank} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [FrmW-1:0] frame_q, frame_d;
    logic            blink_q, blink_d;
    logic [15:0]     snap_digits_q, snap_digits_d;
    logic [3:0]      snap_mask_q, snap_mask_d;
    logic            snap_dp_q, snap_dp_d;
    logic [3:0]      x_q, x_d;
    logic            dec_q, dec_d;
    logic            seg_en_q, seg_en_d;
    logic            frame_start_q, frame_start_d;
    logic            load;
    logic            advance;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        blink_d       = blink_q;
        snap_digits_d = snap_digits_q;
        snap_mask_d   = snap_mask_q;
        snap_dp_d     = snap_dp_q;
        load          = 1'b0;
        advance       = 1'b0;

        // Disable wins over any advance or frame start in the same cycle.
        if (!disp_en_i) begin
            state_d = StOff;
            cnt_d   = '0;
            idx_d   = '0;
            frame_d = '0;
            blink_d = 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StShow;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
                StShow: begin
                    if (cnt_q == ShowLast) begin
                        cnt_d = '0;
                        if (BLANK_CYC == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = StBlank;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        cnt_d   = '0;
                        state_d = StShow;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StOff;
            endcase

            if (advance) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    load = 1'b1;
                    if (frame_q == FrameLast) begin
                        frame_d = '0;
                        blink_d = ~blink_q;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
        end

        if (load) begin
            snap_digits_d = digits_i;
            snap_mask_d   = blink_mask_i;
            snap_dp_d     = dp_in_i;
        end

        // Outputs are computed from next-state values so they register in step with the FSM.
        frame_start_d = load;
        seg_en_d      = (state_d == StShow) && !(blink_d && snap_mask_d[idx_d]);
        x_d           = snap_digits_d[{idx_d, 2'b00} +: 4];
        dec_d         = ~snap_dp_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StOff;
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_q       <= '0;
            blink_q       <= 1'b0;
            snap_digits_q <= '0;
            snap_mask_q   <= '0;
            snap_dp_q     <= 1'b0;
            x_q           <= '0;
            dec_q         <= 1'b1;
            seg_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            blink_q       <= blink_d;
            snap_digits_q <= snap_digits_d;
            snap_mask_q   <= snap_mask_d;
            snap_dp_q     <= snap_dp_d;
            x_q           <= x_d;
            dec_q         <= dec_d;
            seg_en_q      <= seg_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x_o           = x_q;
    assign sw_o          = idx_q;
    assign dec_o         = dec_q;
    assign seg_en_o      = seg_en_q;
    assign frame_start_o = frame_start_q;

endmodule
